dccm_arbiter: RTL and testbench

Shares the DCCM between two requesters: the EXU load/store unit (port 0, LSU) and a DMA/debug loader (port 1, DMA). The DCCM has one read port and one write port, and each is arbitrated independently. The block sits between the EXU and the DCCM in the core top and routes read data back to the requester that issued the read. Arbitration is fixed priority to the LSU, with a starvation guard for the DMA and a same-word read/write collision interlock.

---
 rtl/dccm_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_dccm_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares the DCCM read port and write port between the LSU
// (port 0) and a DMA/debug loader (port 1). Fixed LSU priority per port,
// a per-port starvation guard for the DMA and a same-word read/write
// interlock. Read data is routed back using an owner shift register.
// Optional build macro: DCCM_ARB_PERF_EN adds wait/collision counters.
module dccm_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_gnt,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_rvalid,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dccm_raddr,
  output logic            dccm_rvalid_in,
  input  logic [XLEN-1:0] dccm_rdata,
  input  logic            dccm_rvalid_out,
  output logic [XLEN-1:0] dccm_waddr,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_wdata
`ifdef DCCM_ARB_PERF_EN
  ,
  output logic [XLEN-1:0] perf_lsu_wait,
  output logic [XLEN-1:0] perf_dma_wait,
  output logic [XLEN-1:0] perf_collision
`endif
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                  lsu_rd_s, lsu_wr_s, dma_rd_s, dma_wr_s;
  logic                  same_word_s, rd_collide_s;
  logic                  lsu_rd_gnt_s, dma_rd_gnt_s, lsu_wr_gnt_s, dma_wr_gnt_s;
  logic [3:0]            rd_starve_r, wr_starve_r;
  logic [RD_LATENCY-1:0] own_vld_r, own_dma_r;
  logic                  tail_vld_s, tail_dma_s;
  logic                  orphan_err_r;

  // Classify each requester as a read or write candidate and detect a same-word collision
  always_comb begin
    lsu_rd_s     = lsu_req & ~lsu_we;
    lsu_wr_s     = lsu_req &  lsu_we;
    dma_rd_s     = dma_req & ~dma_we;
    dma_wr_s     = dma_req &  dma_we;
    same_word_s  = (lsu_addr[XLEN-1:2] == dma_addr[XLEN-1:2]);
    rd_collide_s = same_word_s & ((lsu_rd_s & dma_wr_s) | (dma_rd_s & lsu_wr_s));
  end

  // Read and write port arbitration; the collision interlock beats a forced DMA grant
  always_comb begin
    lsu_rd_gnt_s = 1'b0;
    dma_rd_gnt_s = 1'b0;
    lsu_wr_gnt_s = 1'b0;
    dma_wr_gnt_s = 1'b0;
    if (!rst_n) begin
      lsu_rd_gnt_s = 1'b0;
      dma_rd_gnt_s = 1'b0;
    end else if (rd_collide_s) begin
      lsu_rd_gnt_s = 1'b0;
      dma_rd_gnt_s = 1'b0;
    end else if (lsu_rd_s && dma_rd_s) begin
      if (rd_starve_r == STARVE_MAX) begin
        dma_rd_gnt_s = 1'b1;
      end else begin
        lsu_rd_gnt_s = 1'b1;
      end
    end else begin
      lsu_rd_gnt_s = lsu_rd_s;
      dma_rd_gnt_s = dma_rd_s;
    end
    if (!rst_n) begin
      lsu_wr_gnt_s = 1'b0;
      dma_wr_gnt_s = 1'b0;
    end else if (lsu_wr_s && dma_wr_s) begin
      if (wr_starve_r == STARVE_MAX) begin
        dma_wr_gnt_s = 1'b1;
      end else begin
        lsu_wr_gnt_s = 1'b1;
      end
    end else begin
      lsu_wr_gnt_s = lsu_wr_s;
      dma_wr_gnt_s = dma_wr_s;
    end
  end

  // Drive grants and the DCCM ports from the winners; idle ports are held at zero
  always_comb begin
    lsu_gnt        = lsu_rd_gnt_s | lsu_wr_gnt_s;
    dma_gnt        = dma_rd_gnt_s | dma_wr_gnt_s;
    dccm_rvalid_in = lsu_rd_gnt_s | dma_rd_gnt_s;
    dccm_wen       = lsu_wr_gnt_s | dma_wr_gnt_s;
    dccm_raddr     = '0;
    dccm_waddr     = '0;
    dccm_wdata     = '0;
    if (lsu_rd_gnt_s) begin
      dccm_raddr = lsu_addr;
    end else if (dma_rd_gnt_s) begin
      dccm_raddr = dma_addr;
    end else begin
      dccm_raddr = '0;
    end
    if (lsu_wr_gnt_s) begin
      dccm_waddr = lsu_addr;
      dccm_wdata = lsu_wdata;
    end else if (dma_wr_gnt_s) begin
      dccm_waddr = dma_addr;
      dccm_wdata = dma_wdata;
    end else begin
      dccm_waddr = '0;
      dccm_wdata = '0;
    end
  end

  // Starvation counters: count denied DMA cycles per port, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_starve_r <= 4'd0;
      wr_starve_r <= 4'd0;
    end else begin
      if (!dma_req || dma_rd_gnt_s) begin
        rd_starve_r <= 4'd0;
      end else if (dma_rd_s && (rd_starve_r < STARVE_MAX)) begin
        rd_starve_r <= rd_starve_r + 4'd1;
      end else begin
        rd_starve_r <= rd_starve_r;
      end
      if (!dma_req || dma_wr_gnt_s) begin
        wr_starve_r <= 4'd0;
      end else if (dma_wr_s && (wr_starve_r < STARVE_MAX)) begin
        wr_starve_r <= wr_starve_r + 4'd1;
      end else begin
        wr_starve_r <= wr_starve_r;
      end
    end
  end

  // Owner shift register: one {valid, is_dma} entry per cycle of DCCM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_vld_r <= '0;
      own_dma_r <= '0;
    end else begin
      own_vld_r[0] <= lsu_rd_gnt_s | dma_rd_gnt_s;
      own_dma_r[0] <= dma_rd_gnt_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        own_vld_r[i] <= own_vld_r[i-1];
        own_dma_r[i] <= own_dma_r[i-1];
      end
    end
  end

  assign tail_vld_s = own_vld_r[RD_LATENCY-1];
  assign tail_dma_s = own_dma_r[RD_LATENCY-1];

  // Route returning read data to the owner recorded at the tail of the shift register
  always_comb begin
    lsu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    lsu_rdata  = '0;
    dma_rdata  = '0;
    if (rst_n && dccm_rvalid_out && tail_vld_s) begin
      if (tail_dma_s) begin
        dma_rvalid = 1'b1;
        dma_rdata  = dccm_rdata;
      end else begin
        lsu_rvalid = 1'b1;
        lsu_rdata  = dccm_rdata;
      end
    end else begin
      lsu_rvalid = 1'b0;
      dma_rvalid = 1'b0;
    end
  end

  // Sticky flag for DCCM read data that no granted read is waiting for
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orphan_err_r <= 1'b0;
    end else if (dccm_rvalid_out && !tail_vld_s) begin
      orphan_err_r <= 1'b1;
    end else begin
      orphan_err_r <= orphan_err_r;
    end
  end

`ifdef DCCM_ARB_PERF_EN
  logic [31:0] lsu_wait_cnt_r, dma_wait_cnt_r, collision_cnt_r;

  // Wrapping performance counters for requester wait cycles and read collisions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsu_wait_cnt_r  <= 32'd0;
      dma_wait_cnt_r  <= 32'd0;
      collision_cnt_r <= 32'd0;
    end else begin
      if (lsu_req && !lsu_gnt) begin
        lsu_wait_cnt_r <= lsu_wait_cnt_r + 32'd1;
      end
      if (dma_req && !dma_gnt) begin
        dma_wait_cnt_r <= dma_wait_cnt_r + 32'd1;
      end
      if (rd_collide_s) begin
        collision_cnt_r <= collision_cnt_r + 32'd1;
      end
    end
  end

  assign perf_lsu_wait  = XLEN'(lsu_wait_cnt_r);
  assign perf_dma_wait  = XLEN'(dma_wait_cnt_r);
  assign perf_collision = XLEN'(collision_cnt_r);
`endif

endmodule

// File: tb/tb_dccm_arbiter.sv
// Scoreboard bench for dccm_arbiter: two instances (RD_LATENCY 1 and 2) share
// the same stimulus; a bench DCCM model answers reads for each instance.
module tb_dccm_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lsu_req, lsu_we, dma_req, dma_we;
  logic [31:0] lsu_addr, lsu_wdata, dma_addr, dma_wdata;

  logic        lsu_gnt [2], dma_gnt [2], lsu_rvalid [2], dma_rvalid [2];
  logic        rvin [2], wen [2], rvout [2];
  logic [31:0] lsu_rdata [2], dma_rdata [2], raddr [2], waddr [2], wdata [2], rdin [2];
`ifdef DCCM_ARB_PERF_EN
  logic [31:0] p_lw [2], p_dw [2], p_col [2];
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          at;
  } resp_t;
  resp_t q0[$];
  resp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dccm_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt[0]), .lsu_rdata(lsu_rdata[0]), .lsu_rvalid(lsu_rvalid[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt[0]), .dma_rdata(dma_rdata[0]), .dma_rvalid(dma_rvalid[0]),
    .dccm_raddr(raddr[0]), .dccm_rvalid_in(rvin[0]), .dccm_rdata(rdin[0]),
    .dccm_rvalid_out(rvout[0]), .dccm_waddr(waddr[0]), .dccm_wen(wen[0]),
    .dccm_wdata(wdata[0])
`ifdef DCCM_ARB_PERF_EN
    , .perf_lsu_wait(p_lw[0]), .perf_dma_wait(p_dw[0]), .perf_collision(p_col[0])
`endif
  );

  dccm_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt[1]), .lsu_rdata(lsu_rdata[1]), .lsu_rvalid(lsu_rvalid[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt[1]), .dma_rdata(dma_rdata[1]), .dma_rvalid(dma_rvalid[1]),
    .dccm_raddr(raddr[1]), .dccm_rvalid_in(rvin[1]), .dccm_rdata(rdin[1]),
    .dccm_rvalid_out(rvout[1]), .dccm_waddr(waddr[1]), .dccm_wen(wen[1]),
    .dccm_wdata(wdata[1])
`ifdef DCCM_ARB_PERF_EN
    , .perf_lsu_wait(p_lw[1]), .perf_dma_wait(p_dw[1]), .perf_collision(p_col[1])
`endif
  );

  // DCCM model: unwritten word i reads as 0xC0DE0000 + i
  logic [31:0]  mem [256];
  logic [255:0] written = '0;
  logic         p1_v = 1'b0, p2a_v = 1'b0, p2b_v = 1'b0;
  logic [31:0]  p1_d = 32'd0, p2a_d = 32'd0, p2b_d = 32'd0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return written[idx] ? mem[idx] : (32'hC0DE_0000 + {24'd0, idx});
  endfunction

  always @(posedge clk) begin
    if (wen[0]) begin
      mem[waddr[0][9:2]]     <= wdata[0];
      written[waddr[0][9:2]] <= 1'b1;
    end
    p1_v  <= rvin[0];
    p1_d  <= rd_word(raddr[0]);
    p2a_v <= rvin[1];
    p2a_d <= rd_word(raddr[1]);
    p2b_v <= p2a_v;
    p2b_d <= p2a_d;
  end

  assign rvout[0] = p1_v;
  assign rdin[0]  = p1_d;
  assign rvout[1] = p2b_v;
  assign rdin[1]  = p2b_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input int k);
    chk({nm, "_ctrl"}, {26'd0, lsu_gnt[k], dma_gnt[k], lsu_rvalid[k], dma_rvalid[k],
                        rvin[k], wen[k]}, 32'd0);
    chk({nm, "_data"}, lsu_rdata[k] | dma_rdata[k] | raddr[k] | waddr[k] | wdata[k], 32'd0);
  endtask

  // Monitor: pops the expected response whenever an instance presents read data
  task automatic mon(input int k);
    resp_t e;
    logic  have;
    have = 1'b0;
    if (lsu_rvalid[k] || dma_rvalid[k]) begin
      if (k == 0 && q0.size() > 0) begin
        e = q0.pop_front();
        have = 1'b1;
      end else if (k == 1 && q1.size() > 0) begin
        e = q1.pop_front();
        have = 1'b1;
      end
      if (!have) begin
        chk($sformatf("unexpected_rvalid%0d", k), 32'd1, 32'd0);
      end else begin
        chk($sformatf("rsp_port%0d", k), {31'd0, dma_rvalid[k]}, {31'd0, e.port});
        chk($sformatf("rsp_data%0d", k), dma_rvalid[k] ? dma_rdata[k] : lsu_rdata[k], e.data);
        chk($sformatf("rsp_cycle%0d", k), cyc, e.at);
        chk($sformatf("other_rdata%0d", k), dma_rvalid[k] ? lsu_rdata[k] : dma_rdata[k], 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  // One cycle of stimulus with hand-computed grants and read data
  task automatic step(input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                      input logic elg, input logic edg, input logic [31:0] eld,
                      input logic [31:0] edd, input logic push);
    logic        er, ew;
    logic [31:0] ra, wa, wd;
    lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = lwd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dwd;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lsu_gnt%0d", k), {31'd0, lsu_gnt[k]}, {31'd0, elg});
      chk($sformatf("dma_gnt%0d", k), {31'd0, dma_gnt[k]}, {31'd0, edg});
    end
    er = (elg & ~lw) | (edg & ~dw);
    ew = (elg & lw) | (edg & dw);
    ra = (elg & ~lw) ? la : ((edg & ~dw) ? da : 32'd0);
    wa = (elg & lw) ? la : ((edg & dw) ? da : 32'd0);
    wd = (elg & lw) ? lwd : ((edg & dw) ? dwd : 32'd0);
    chk("dccm_rvalid_in", {31'd0, rvin[0]}, {31'd0, er});
    chk("dccm_wen", {31'd0, wen[0]}, {31'd0, ew});
    chk("dccm_raddr", raddr[0], ra);
    chk("dccm_waddr", waddr[0], wa);
    chk("dccm_wdata", wdata[0], wd);
    if (push) begin
      if (elg & ~lw) begin
        q0.push_back('{1'b0, eld, cyc + 1});
        q1.push_back('{1'b0, eld, cyc + 2});
      end
      if (edg & ~dw) begin
        q0.push_back('{1'b1, edd, cyc + 1});
        q1.push_back('{1'b1, edd, cyc + 2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
  endtask

  initial begin
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    @(posedge clk);
    #1;
    // requests during reset must not be granted
    lsu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200;
    @(negedge clk);
    chk_idle("reset1", 0);
    chk_idle("reset2", 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // LSU read and DMA write together
    step(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b1, 32'h200, 32'h1111_2222,
         1'b1, 1'b1, 32'hC0DE_0040, 32'd0, 1'b1);
    idle(2);

    // both read continuously: DMA forced on every 5th cycle
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h300, 32'd0,
           (k % 5) != 4, (k % 5) == 4, 32'hC0DE_0004, 32'hC0DE_00C0, 1'b1);
    end
    idle(1);

    // DMA write / LSU read same word: write first, read sees new data
    step(1'b1, 1'b0, 32'h43, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'h43, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,
         1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    // LSU write / DMA read different words: both granted
    step(1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b1, 1'b0, 32'h84, 32'd0,
         1'b1, 1'b1, 32'd0, 32'hC0DE_0021, 1'b1);
    // LSU write / DMA read same word
    step(1'b1, 1'b1, 32'h88, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h8A, 32'd0,
         1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h8A, 32'd0,
         1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b1);

    // both write continuously: DMA forced on the 5th cycle
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 32'h60, k, 1'b1, 1'b1, 32'h64, 32'h77,
           k != 4, k == 4, 32'd0, 32'd0, 1'b1);
    end
    step(1'b1, 1'b1, 32'h60, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0,
         1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'h60, 32'd0, 1'b1, 1'b0, 32'h64, 32'd0,
         1'b1, 1'b0, 32'h4, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h64, 32'd0,
         1'b0, 1'b1, 32'd0, 32'h77, 1'b1);

    // alternating single reads, checked for order and latency on both instances
    step(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hC0DE_0000, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b1, 32'd0, 32'hC0DE_0001, 1'b1);
    step(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hC0DE_0002, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hC, 32'd0, 1'b0, 1'b1, 32'd0, 32'hC0DE_0003, 1'b1);
    idle(3);

    // DMA read granted, then reset while the DCCM answers: response dropped
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h30, 32'd0,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    lsu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rvalid_out_seen", {31'd0, rvout[0]}, 32'd1);
    chk_idle("midrst1", 0);
    chk_idle("midrst2", 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid_out_seen", {31'd0, rvout[1]}, 32'd1);
    chk("post_rst_lsu_rvalid2", {31'd0, lsu_rvalid[1]}, 32'd0);
    chk("post_rst_dma_rvalid2", {31'd0, dma_rvalid[1]}, 32'd0);
    @(posedge clk);
    #1;

    // 3 collision cycles, 2 LSU wait cycles, 1 DMA wait cycle since reset
    step(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b1, 32'h100, 32'hAAAA_0001,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b1, 32'h100, 32'hAAAA_0002,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0,
         1'b1, 1'b0, 32'hAAAA_0002, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h140, 32'hBBBB_0003, 1'b1, 1'b0, 32'h140, 32'd0,
         1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h140, 32'd0,
         1'b0, 1'b1, 32'd0, 32'hBBBB_0003, 1'b1);
    idle(1);
`ifdef DCCM_ARB_PERF_EN
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("perf_collision%0d", k), p_col[k], 32'd3);
      chk($sformatf("perf_lsu_wait%0d", k), p_lw[k], 32'd2);
      chk($sformatf("perf_dma_wait%0d", k), p_dw[k], 32'd1);
    end
`endif
    idle(3);
    chk("pending_responses", q0.size() + q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
